// File: rtl/cbc_uart_pkg.sv
// Shared definitions for the CBC configuration UART: FSM states, packet sizes
// and the default bit period.
package cbc_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    localparam int unsigned CMD_BYTES     = 3;
    localparam int unsigned RSP_BYTES     = 2;
    localparam int unsigned BAUD_DIV_DFLT = 868;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser, mid-bit sampler and LSB-first
// shift register. Reports each byte with a good or bad stop bit.
module uart_rx_byte
    import cbc_uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_DFLT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_vld,
    output logic       stop_err,
    output logic       busy
);

    localparam int unsigned   CW       = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2 - 1);

    uart_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          prev_q, prev_d;
    logic          vld_q, vld_d;
    logic          err_q, err_d;

    always_comb begin
        sync1_d = rx;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                // A start bit that is high again at mid-bit was only a glitch.
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    sh_d  = {sync2_q, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (sync2_q) vld_d = 1'b1;
                    else         err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    assign rx_byte  = sh_q;
    assign byte_vld = vld_q;
    assign stop_err = err_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: rtl/cfg_host_uart.sv
// Host end of the CBC configuration link: sends 3-byte commands on TX and
// assembles 2-byte responses from RX.
module cfg_host_uart
    import cbc_uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = BAUD_DIV_DFLT,
    parameter int unsigned RX_GAP_MAX = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] cmd_data,
    input  logic        snd_cmd,
    output logic        cmd_busy,
    output logic        TX,
    input  logic        RX,
    output logic [15:0] rsp_data,
    output logic        rsp_rdy,
    input  logic        clr_rsp_rdy,
    output logic        rsp_ovr,
    output logic        frm_err
);

    localparam int unsigned   CW        = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(BAUD_DIV - 1);
    localparam logic [1:0]    LAST_BYTE = 2'(CMD_BYTES - 1);
    // Byte 0 is accepted at mid-stop, so half a bit of stop remains before the gap.
    localparam int unsigned   GAP_LIM   = RX_GAP_MAX * BAUD_DIV + BAUD_DIV / 2;
    localparam int unsigned   GW        = $clog2(GAP_LIM + 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_LIM - 1);

    uart_state_e   tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [1:0]    tx_byte_q, tx_byte_d;
    logic [23:0]   cmd_lat_q, cmd_lat_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic [7:0]    tx_cur;

    always_comb begin
        case (tx_byte_q)
            2'd0:    tx_cur = cmd_lat_q[23:16];
            2'd1:    tx_cur = cmd_lat_q[15:8];
            default: tx_cur = cmd_lat_q[7:0];
        endcase
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_byte_d  = tx_byte_q;
        cmd_lat_d  = cmd_lat_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        case (tx_state_q)
            IDLE: begin
                if (snd_cmd) begin
                    cmd_lat_d  = cmd_data;
                    busy_d     = 1'b1;
                    tx_d       = 1'b0;
                    tx_cnt_d   = '0;
                    tx_byte_d  = '0;
                    tx_state_d = START;
                end
            end
            START: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_d       = tx_cur[0];
                    tx_state_d = DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_d       = 1'b1;
                        tx_state_d = STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                        tx_d     = tx_cur[tx_bit_q + 3'd1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_byte_q == LAST_BYTE) begin
                        busy_d     = 1'b0;
                        tx_state_d = IDLE;
                    end else begin
                        tx_byte_d  = tx_byte_q + 2'd1;
                        tx_d       = 1'b0;
                        tx_state_d = START;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = IDLE;
        endcase
    end

    logic [7:0] rx_byte;
    logic       rx_vld;
    logic       rx_err;
    logic       rx_busy;

    uart_rx_byte #(
        .BAUD_DIV(BAUD_DIV)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx       (RX),
        .rx_byte  (rx_byte),
        .byte_vld (rx_vld),
        .stop_err (rx_err),
        .busy     (rx_busy)
    );

    logic          sel_q, sel_d;
    logic [7:0]    hi_q, hi_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [15:0]   rsp_q, rsp_d;
    logic          rdy_q, rdy_d;
    logic          ovr_q, ovr_d;
    logic          ferr_q, ferr_d;

    always_comb begin
        sel_d  = sel_q;
        hi_d   = hi_q;
        gap_d  = gap_q;
        rsp_d  = rsp_q;
        rdy_d  = rdy_q;
        ovr_d  = 1'b0;
        ferr_d = 1'b0;
        if (clr_rsp_rdy) rdy_d = 1'b0;
        if (rx_err) begin
            ferr_d = 1'b1;
            sel_d  = 1'b0;
        end else if (rx_vld) begin
            if (!sel_q) begin
                hi_d  = rx_byte;
                sel_d = 1'b1;
                gap_d = '0;
            end else begin
                rsp_d = {hi_q, rx_byte};
                rdy_d = 1'b1;
                ovr_d = rdy_q;
                sel_d = 1'b0;
            end
        end else if (sel_q && !rx_busy) begin
            if (gap_q == GAP_LAST) begin
                ferr_d = 1'b1;
                sel_d  = 1'b0;
            end else begin
                gap_d = gap_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_byte_q  <= '0;
            cmd_lat_q  <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            sel_q      <= 1'b0;
            hi_q       <= '0;
            gap_q      <= '0;
            rsp_q      <= '0;
            rdy_q      <= 1'b0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_byte_q  <= tx_byte_d;
            cmd_lat_q  <= cmd_lat_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            sel_q      <= sel_d;
            hi_q       <= hi_d;
            gap_q      <= gap_d;
            rsp_q      <= rsp_d;
            rdy_q      <= rdy_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
        end
    end

    assign TX       = tx_q;
    assign cmd_busy = busy_q;
    assign rsp_data = rsp_q;
    assign rsp_rdy  = rdy_q;
    assign rsp_ovr  = ovr_q;
    assign frm_err  = ferr_q;

endmodule

// File: tb/tb_cfg_host_uart.sv
// Directed bench for cfg_host_uart at BAUD_DIV=16: reset, command framing,
// response assembly, overrun, framing errors and mid-packet reset.
module tb_cfg_host_uart;

    localparam int unsigned BD = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] cmd_data = '0;
    logic        snd_cmd = 1'b0;
    logic        cmd_busy;
    logic        TX;
    logic        RX = 1'b1;
    logic [15:0] rsp_data;
    logic        rsp_rdy;
    logic        clr_rsp_rdy = 1'b0;
    logic        rsp_ovr;
    logic        frm_err;

    int checks = 0;
    int errors = 0;
    int ovr_cnt = 0;
    int ferr_cnt = 0;

    cfg_host_uart #(
        .BAUD_DIV   (BD),
        .RX_GAP_MAX (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_data    (cmd_data),
        .snd_cmd     (snd_cmd),
        .cmd_busy    (cmd_busy),
        .TX          (TX),
        .RX          (RX),
        .rsp_data    (rsp_data),
        .rsp_rdy     (rsp_rdy),
        .clr_rsp_rdy (clr_rsp_rdy),
        .rsp_ovr     (rsp_ovr),
        .frm_err     (frm_err)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled just after each edge so tasks can read them at negedge.
    always @(posedge clk) begin
        #1;
        if (rsp_ovr === 1'b1) ovr_cnt++;
        if (frm_err === 1'b1) ferr_cnt++;
    end

    function automatic logic [29:0] frame_of(input logic [23:0] d);
        logic [29:0] f;
        logic [7:0]  b;
        for (int k = 0; k < 3; k++) begin
            b = d[23-8*k -: 8];
            f[10*k] = 1'b0;
            for (int i = 0; i < 8; i++) f[10*k+1+i] = b[i];
            f[10*k+9] = 1'b1;
        end
        return f;
    endfunction

    task automatic drive_rx_byte(input logic [7:0] b, input logic stop_bit);
        RX = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BD) @(negedge clk);
        end
        RX = stop_bit;
        repeat (BD) @(negedge clk);
        RX = 1'b1;
    endtask

    task automatic pulse_clear();
        clr_rsp_rdy = 1'b1;
        @(negedge clk);
        clr_rsp_rdy = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (TX !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b, expected 1", TX); end
        checks++; if (cmd_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", cmd_busy); end
        checks++; if (rsp_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b, expected 0", rsp_rdy); end
        checks++; if (rsp_data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h, expected 0000", rsp_data); end
        checks++; if ({rsp_ovr, frm_err} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b, expected 00", {rsp_ovr, frm_err}); end
        rst = 1'b0;
        bad = 0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (TX !== 1'b1 || cmd_busy !== 1'b0 || rsp_rdy !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL idle_hold: got %0d bad cycles, expected 0", bad); end
    endtask

    task automatic test_tx();
        logic [29:0] f;
        f = frame_of(24'hA53C0F);
        cmd_data = 24'hA53C0F;
        snd_cmd  = 1'b1;
        for (int n = 0; n < 480; n++) begin
            @(negedge clk);
            checks++;
            if (TX !== f[n/16]) begin
                errors++; $display("FAIL tx_bit cycle %0d: got %b, expected %b", n, TX, f[n/16]);
            end
            checks++;
            if (cmd_busy !== 1'b1) begin
                errors++; $display("FAIL tx_busy cycle %0d: got %b, expected 1", n, cmd_busy);
            end
            // Requests while busy, including the cycle busy falls, must be dropped.
            snd_cmd  = (n == 100) || (n == 479);
            cmd_data = 24'hFFFFFF;
        end
        @(negedge clk);
        snd_cmd = 1'b0;
        checks++; if (cmd_busy !== 1'b0) begin errors++; $display("FAIL tx_busy_end: got %b, expected 0", cmd_busy); end
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            checks++;
            if ({TX, cmd_busy} !== 2'b10) begin
                errors++; $display("FAIL tx_ignored cycle %0d: got TX=%b busy=%b, expected TX=1 busy=0", n, TX, cmd_busy);
            end
        end
    endtask

    task automatic test_rx_basic();
        int o0, f0;
        o0 = ovr_cnt; f0 = ferr_cnt;
        drive_rx_byte(8'h12, 1'b1);
        drive_rx_byte(8'h34, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (rsp_rdy !== 1'b1) begin errors++; $display("FAIL rx_rdy: got %b, expected 1", rsp_rdy); end
        checks++; if (rsp_data !== 16'h1234) begin errors++; $display("FAIL rx_data: got %h, expected 1234", rsp_data); end
        checks++; if (ovr_cnt - o0 !== 0) begin errors++; $display("FAIL rx_no_ovr: got %0d, expected 0", ovr_cnt - o0); end
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL rx_no_ferr: got %0d, expected 0", ferr_cnt - f0); end
        pulse_clear();
        checks++; if (rsp_rdy !== 1'b0) begin errors++; $display("FAIL rx_clr: got %b, expected 0", rsp_rdy); end
        checks++; if (rsp_data !== 16'h1234) begin errors++; $display("FAIL rx_data_kept: got %h, expected 1234", rsp_data); end
    endtask

    task automatic test_overrun();
        int o0;
        o0 = ovr_cnt;
        drive_rx_byte(8'h12, 1'b1);
        drive_rx_byte(8'h34, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (ovr_cnt - o0 !== 0) begin errors++; $display("FAIL ovr_first: got %0d, expected 0", ovr_cnt - o0); end
        drive_rx_byte(8'hBE, 1'b1);
        drive_rx_byte(8'hEF, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (ovr_cnt - o0 !== 1) begin errors++; $display("FAIL ovr_count: got %0d, expected 1", ovr_cnt - o0); end
        checks++; if (rsp_data !== 16'hBEEF) begin errors++; $display("FAIL ovr_data: got %h, expected beef", rsp_data); end
        checks++; if (rsp_rdy !== 1'b1) begin errors++; $display("FAIL ovr_rdy: got %b, expected 1", rsp_rdy); end
        pulse_clear();
    endtask

    task automatic test_frame_err();
        int f0;
        f0 = ferr_cnt;
        drive_rx_byte(8'h55, 1'b0);
        repeat (2*BD) @(negedge clk);
        checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_stop: got %0d, expected 1", ferr_cnt - f0); end
        checks++; if (rsp_rdy !== 1'b0) begin errors++; $display("FAIL ferr_stop_rdy: got %b, expected 0", rsp_rdy); end
        drive_rx_byte(8'hAA, 1'b1);
        repeat (17*BD) @(negedge clk);
        checks++; if (ferr_cnt - f0 !== 2) begin errors++; $display("FAIL ferr_gap: got %0d, expected 2", ferr_cnt - f0); end
        checks++; if (rsp_rdy !== 1'b0) begin errors++; $display("FAIL ferr_gap_rdy: got %b, expected 0", rsp_rdy); end
        drive_rx_byte(8'h00, 1'b1);
        drive_rx_byte(8'h01, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (rsp_rdy !== 1'b1) begin errors++; $display("FAIL ferr_recover_rdy: got %b, expected 1", rsp_rdy); end
        checks++; if (rsp_data !== 16'h0001) begin errors++; $display("FAIL ferr_recover_data: got %h, expected 0001", rsp_data); end
        checks++; if (ferr_cnt - f0 !== 2) begin errors++; $display("FAIL ferr_recover_count: got %0d, expected 2", ferr_cnt - f0); end
        pulse_clear();
    endtask

    task automatic test_reset_mid();
        logic [29:0] f;
        cmd_data = 24'h123456;
        snd_cmd  = 1'b1;
        @(negedge clk);
        snd_cmd = 1'b0;
        repeat (200) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (TX !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b, expected 1", TX); end
        checks++; if (cmd_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b, expected 0", cmd_busy); end
        rst = 1'b0;
        @(negedge clk);
        f = frame_of(24'hC3817E);
        cmd_data = 24'hC3817E;
        snd_cmd  = 1'b1;
        for (int n = 0; n < 480; n++) begin
            @(negedge clk);
            snd_cmd = 1'b0;
            if (n % 16 == 8) begin
                checks++;
                if (TX !== f[n/16]) begin
                    errors++; $display("FAIL rstmid_frame bit %0d: got %b, expected %b", n/16, TX, f[n/16]);
                end
            end
        end
        @(negedge clk);
        checks++; if ({TX, cmd_busy} !== 2'b10) begin errors++; $display("FAIL rstmid_end: got %b, expected 10", {TX, cmd_busy}); end
    endtask

    initial begin
        test_reset();
        test_tx();
        test_rx_basic();
        test_overrun();
        test_frame_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
